soc1_sysid_checker: RTL
=======================

# soc1_sysid_checker

Boot-time system-identity checker that is the direct consumer of the SoC1 system-ID control slave. On request it reads the ID word (offset 0) and the timestamp word (offset 1) over a minimal Avalon-MM read interface. It compares both against build-time expected values and presents the captured words plus pass/fail flags to the boot controller. It sits between the system-ID slave and the reset/boot sequencer, gating software release on a matching hardware image.

## Interface
Parameters:
- EXPECTED_ID, 32'd0, ID word the hardware must report.
- EXPECTED_TIMESTAMP, 32'd1730379950, timestamp word the hardware must report.
- READ_LATENCY, 0, slave read latency in cycles, legal range 0..3.
- RECHECK_PERIOD, 1024, idle cycles in DONE before an automatic re-check; used only with the periodic feature; minimum 1.

Ports:
- clock  in  1  single clock for the whole block.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request to run a check; sampled only in IDLE or DONE.
- sysid_address  out  1  word offset to the slave: 0 = ID, 1 = timestamp.
- sysid_read  out  1  read strobe, high exactly one cycle per word.
- sysid_readdata  in  32  read data from the slave.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  high in every cycle the FSM is in DONE.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.
- id_ok  out  1  id_value == EXPECTED_ID.
- ts_ok  out  1  ts_value == EXPECTED_TIMESTAMP.
- match  out  1  id_ok & ts_ok & done.

## Operation
- FSM states:
  - IDLE -> RD_ID on start.
  - RD_ID -> WAIT_ID, or directly to RD_TS when READ_LATENCY=0.
  - WAIT_ID -> RD_TS after the latency count expires.
  - RD_TS -> WAIT_TS, or directly to DONE when READ_LATENCY=0.
  - WAIT_TS -> DONE after the latency count expires.
  - DONE -> RD_ID on start.
- In RD_ID / RD_TS, drive sysid_read=1 with sysid_address=0 / 1.
- sysid_address holds its value through the following WAIT state. In all other states it is 0 and sysid_read is 0.
- Latency counter: 2 bits, loaded with READ_LATENCY in each RD state, decremented in WAIT. Capture occurs when it reaches 0.
- Capture: sysid_readdata is registered into id_value or ts_value on the clock edge ending cycle T+READ_LATENCY, where T is the read cycle.
- id_ok and ts_ok are registered comparisons, updated on the same edge as their value register.
- Captured values and flags persist until overwritten by the next check. They are not cleared on start.
- start while busy is ignored: no queuing, no restart.

## Timing
- Reset (async assert, sync release): state=IDLE. All outputs are 0, including id_value=0, ts_value=0, and all flags 0.
- Latency from start-sampled edge to done high is 3 + 2*READ_LATENCY cycles. With READ_LATENCY=0 this is 3 cycles.
- busy and done are never high together. busy falls on the same edge that done rises.
- start in DONE: done falls and busy rises on the next edge. That edge is also the RD_ID cycle.
- Reset mid-operation aborts immediately. Any partial capture is discarded to 0. No read strobe is emitted after reset_n falls.
- Mismatch is reported, not retried. The FSM still reaches DONE with match=0.

## Configuration
- SYSID_CHECKER_PERIODIC_EN defined: while in DONE, a down-counter loaded with RECHECK_PERIOD-1 on DONE entry expires and forces DONE -> RD_ID as if start were pulsed. An explicit start in DONE takes effect immediately and reloads the counter on the next DONE entry.
- Not defined: DONE is held until start or reset. The timer logic is absent.

## Structure
- Shared package soc1_sysid_pkg holds:
  - state enum: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
  - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1.
  - SYSID_DATA_W=32.
- One sub-module, soc1_sysid_recheck_timer (load, enable, expired), instantiated only under SYSID_CHECKER_PERIODIC_EN.

## Test plan
- Reset, then start with the slave returning 0 at offset 0 and 1730379950 at offset 1, READ_LATENCY=0 -> done high 3 cycles after start; id_ok=ts_ok=match=1; exactly two read strobes, at addresses 0 then 1.
- Slave returns 0x12345678 at offset 1 -> ts_value=0x12345678, ts_ok=0, id_ok=1, match=0, done=1.
- READ_LATENCY=2 with a slave model delaying data 2 cycles -> done at 7 cycles; captured values correct; address held through the WAIT states.
- start pulsed during RD_TS -> ignored; exactly one check completes; restart from DONE re-reads both words.
- reset_n dropped during WAIT_ID -> all outputs 0 asynchronously; after release, idle until start.
- With SYSID_CHECKER_PERIODIC_EN and RECHECK_PERIOD=4 -> a new RD_ID strobe appears 4 cycles after each DONE entry, with no start pulse.

Source files
------------

// File: rtl/soc1_sysid_pkg.sv
// Shared types and constants for the SoC1 system-ID checker and its helpers.
package soc1_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    DONE
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int   SYSID_DATA_W  = 32;

endpackage

// File: rtl/soc1_sysid_checker_recheck_timer.sv
// Idle timer for the periodic re-check option (SYSID_CHECKER_PERIODIC_EN).
// expired is high while enabled once PERIOD enabled cycles have elapsed since load.
module soc1_sysid_recheck_timer #(
  parameter int PERIOD = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(PERIOD - 1);
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/soc1_sysid_checker.sv
// Boot-time system-ID checker: reads ID and timestamp words and compares them with build-time values.
// Define SYSID_CHECKER_PERIODIC_EN to re-run the check automatically after RECHECK_PERIOD idle cycles in DONE.
module soc1_sysid_checker
  import soc1_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1730379950,
  parameter int          READ_LATENCY       = 0,
  parameter int          RECHECK_PERIOD     = 1024
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    sysid_address,
  output logic                    sysid_read,
  input  logic [SYSID_DATA_W-1:0] sysid_readdata,
  output logic                    busy,
  output logic                    done,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    match
);

  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  if ((READ_LATENCY < 0) || (READ_LATENCY > 3)) begin : g_bad_latency
    $error("soc1_sysid_checker: READ_LATENCY must be 0..3");
  end
  if (RECHECK_PERIOD < 1) begin : g_bad_period
    $error("soc1_sysid_checker: RECHECK_PERIOD must be at least 1");
  end

  state_t     state;
  state_t     next_state;
  logic [1:0] lat_cnt;
  logic       capture_id;
  logic       capture_ts;
  logic       recheck;

  // Data is valid in the last cycle of the read window: the RD cycle itself
  // at zero latency, otherwise the WAIT cycle where the count is about to hit 0.
  assign capture_id = ((state == RD_ID) && (LAT == 2'd0)) ||
                      ((state == WAIT_ID) && (lat_cnt == 2'd1));
  assign capture_ts = ((state == RD_TS) && (LAT == 2'd0)) ||
                      ((state == WAIT_TS) && (lat_cnt == 2'd1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RD_ID;
      RD_ID:   next_state = (LAT == 2'd0) ? RD_TS : WAIT_ID;
      WAIT_ID: if (capture_id) next_state = RD_TS;
      RD_TS:   next_state = (LAT == 2'd0) ? DONE : WAIT_TS;
      WAIT_TS: if (capture_ts) next_state = DONE;
      DONE:    if (start || recheck) next_state = RD_ID;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      lat_cnt       <= 2'd0;
      sysid_read    <= 1'b0;
      sysid_address <= SYSID_ADDR_ID;
      busy          <= 1'b0;
      done          <= 1'b0;
      id_value      <= '0;
      ts_value      <= '0;
      id_ok         <= 1'b0;
      ts_ok         <= 1'b0;
    end else begin
      state         <= next_state;
      sysid_read    <= (next_state == RD_ID) || (next_state == RD_TS);
      sysid_address <= ((next_state == RD_TS) || (next_state == WAIT_TS)) ?
                       SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy          <= (next_state == RD_ID) || (next_state == WAIT_ID) ||
                       (next_state == RD_TS) || (next_state == WAIT_TS);
      done          <= (next_state == DONE);

      if ((state == RD_ID) || (state == RD_TS)) begin
        lat_cnt <= LAT;
      end else if (lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end

      if (capture_id) begin
        id_value <= sysid_readdata;
        id_ok    <= (sysid_readdata == EXPECTED_ID);
      end
      if (capture_ts) begin
        ts_value <= sysid_readdata;
        ts_ok    <= (sysid_readdata == EXPECTED_TIMESTAMP);
      end
    end
  end

  assign match = id_ok & ts_ok & done;

`ifdef SYSID_CHECKER_PERIODIC_EN
  logic timer_load;

  // Reload only on the DONE entry edge so an explicit restart re-arms the full period.
  assign timer_load = (next_state == DONE) && (state != DONE);

  soc1_sysid_recheck_timer #(
    .PERIOD (RECHECK_PERIOD)
  ) u_recheck_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (timer_load),
    .enable  (state == DONE),
    .expired (recheck)
  );
`else
  assign recheck = 1'b0;
`endif

endmodule
